// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state/command encodings and default ramp constants; PWM_RAMP_BREATHE_EN adds the breathing states.
package pwm_pkg;
    localparam int DEF_PERIOD = 100;
    localparam int DEF_STEP   = 5;
    typedef enum logic [1:0] {
        MODE_SET  = 2'b00,
        MODE_RAMP = 2'b01,
        MODE_BRTH = 2'b10,
        MODE_STOP = 2'b11
    } mode_t;
    typedef enum logic [1:0] {
        IDLE,
        RAMP
`ifdef PWM_RAMP_BREATHE_EN
        , BRTH_UP,
        BRTH_DN
`endif
    } state_t;
endpackage

// File: rtl/pwm_step_sat.sv
// pwm_step_sat: one saturating duty step toward a limit, flagging when the limit is reached.
module pwm_step_sat #(
    parameter int DW   = 8,
    parameter int STEP = 5
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] lim,
    input  logic          up,
    output logic [DW-1:0] nxt,
    output logic          reached
);
    logic [DW:0] c, l, s;
    assign c = {1'b0, cur};
    assign l = {1'b0, lim};
    assign s = up ? c + (DW+1)'(STEP) : c - (DW+1)'(STEP);
    // s[DW] set on the way down means the subtraction wrapped below zero
    assign reached = up ? s >= l : (s[DW] || s <= l);
    assign nxt = reached ? lim : s[DW-1:0];
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle command controller (SET/RAMP/BREATHE/STOP) stepping on PWM period ticks.
// Define PWM_RAMP_BREATHE_EN to enable breathing; otherwise BREATHE runs as RAMP.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int STEP   = DEF_STEP,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          period_tick,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [DW-1:0] cmd_target,
    output logic [DW-1:0] duty,
    output logic          duty_load,
    output logic          busy,
    output logic          done
);
    state_t state, state_nxt;
    logic [DW-1:0] tgt, tgt_nxt, duty_nxt, clamped, lim, step_nxt;
    logic live, accept, up, reached, done_nxt;
    assign clamped = cmd_target > DW'(PERIOD) ? DW'(PERIOD) : cmd_target;
    assign cmd_ready = live && state != RAMP;
    assign accept = cmd_valid && cmd_ready;
    assign busy = state != IDLE;
`ifdef PWM_RAMP_BREATHE_EN
    assign lim = state == BRTH_DN ? '0 : tgt;
    assign up = state == RAMP ? tgt > duty : state == BRTH_UP;
`else
    assign lim = tgt;
    assign up = tgt > duty;
`endif
    pwm_step_sat #(.DW(DW), .STEP(STEP)) u_step (
        .cur(duty),
        .lim(lim),
        .up(up),
        .nxt(step_nxt),
        .reached(reached)
    );
    always_comb begin
        state_nxt = state;
        tgt_nxt = tgt;
        duty_nxt = duty;
        done_nxt = 1'b0;
        if (accept) begin
            tgt_nxt = clamped;
            // a command arriving mid-breathe completes (aborts) the breathe
            done_nxt = state != IDLE;
            state_nxt = IDLE;
            case (mode_t'(cmd_mode))
                MODE_SET: begin
                    duty_nxt = clamped;
                    done_nxt = 1'b1;
                end
                MODE_STOP: done_nxt = 1'b1;
`ifdef PWM_RAMP_BREATHE_EN
                MODE_BRTH: begin
                    if (clamped == '0) begin
                        duty_nxt = '0;
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = BRTH_UP;
                    end
                end
`endif
                default: begin
                    if (clamped == duty) done_nxt = 1'b1;
                    else state_nxt = RAMP;
                end
            endcase
        end else if (period_tick && state != IDLE) begin
            duty_nxt = step_nxt;
            if (reached) begin
`ifdef PWM_RAMP_BREATHE_EN
                state_nxt = state == BRTH_UP ? BRTH_DN : state == BRTH_DN ? BRTH_UP : IDLE;
`else
                state_nxt = IDLE;
`endif
                done_nxt = state == RAMP;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            duty <= '0;
            tgt <= '0;
            duty_load <= 1'b0;
            done <= 1'b0;
            live <= 1'b0;
        end else begin
            state <= state_nxt;
            duty <= duty_nxt;
            tgt <= tgt_nxt;
            duty_load <= duty_nxt != duty;
            done <= done_nxt;
            live <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: table-driven and scoreboard checks of pwm_ramp_ctrl command handling.
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;
    localparam int PERIOD = 100;
    localparam int STEP = 5;
    localparam int DW = 8;
    typedef struct {
        logic [1:0] mode;
        int tgt;
        int duty;
        bit load;
        bit done;
    } vec_t;
    typedef struct {
        int duty;
        bit load;
        bit done;
        bit busy;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, period_tick = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'b00;
    logic [DW-1:0] cmd_target = '0;
    logic cmd_ready, duty_load, busy, done;
    logic [DW-1:0] duty;
    int checks = 0, failures = 0, cur = 0;
    exp_t q[$];
    vec_t vecs[7];

    pwm_ramp_ctrl #(.PERIOD(PERIOD), .STEP(STEP), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .period_tick(period_tick),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode),
        .cmd_target(cmd_target),
        .duty(duty),
        .duty_load(duty_load),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(logic [1:0] m, int t, bit tk);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_wait", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_mode = m;
        cmd_target = DW'(t);
        period_tick = tk;
        step();
        cmd_valid = 1'b0;
        period_tick = 1'b0;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
    endtask

    task automatic pop_chk(string nm);
        exp_t e;
        if (q.size() == 0) begin
            chk({nm, "_queue_empty"}, 0, 1);
            return;
        end
        e = q.pop_front();
        chk({nm, "_duty"}, int'(duty), e.duty);
        chk({nm, "_load"}, int'(duty_load), int'(e.load));
        chk({nm, "_done"}, int'(done), int'(e.done));
        chk({nm, "_busy"}, int'(busy), int'(e.busy));
    endtask

    // Expected trajectory is pushed before the command goes out, then popped per tick.
    task automatic run_ramp(string nm, logic [1:0] m, int t);
        int tg = t > PERIOD ? PERIOD : t;
        int d = cur;
        int n = 0;
        while (d != tg) begin
            if (d < tg) d = (tg - d <= STEP) ? tg : d + STEP;
            else d = (d - tg <= STEP) ? tg : d - STEP;
            q.push_back('{duty: d, load: 1'b1, done: d == tg, busy: d != tg});
        end
        cmd(m, t, 1'b1);
        chk({nm, "_tick_ignored"}, int'(duty), cur);
        chk({nm, "_busy_start"}, int'(busy), 1);
        chk({nm, "_ready_low"}, int'(cmd_ready), 0);
        while (q.size() != 0 && n < 60) begin
            tick();
            chk({nm, "_ready"}, int'(cmd_ready), int'(!q[0].busy));
            pop_chk(nm);
            step();
            chk({nm, "_gap_load"}, int'(duty_load), 0);
            n++;
        end
        cur = tg;
    endtask

    initial begin
        vecs[0] = '{mode: MODE_SET,  tgt: 40,  duty: 40,  load: 1'b1, done: 1'b1};
        vecs[1] = '{mode: MODE_SET,  tgt: 40,  duty: 40,  load: 1'b0, done: 1'b1};
        vecs[2] = '{mode: MODE_SET,  tgt: 150, duty: 100, load: 1'b1, done: 1'b1};
        vecs[3] = '{mode: MODE_STOP, tgt: 77,  duty: 100, load: 1'b0, done: 1'b1};
        vecs[4] = '{mode: MODE_SET,  tgt: 50,  duty: 50,  load: 1'b1, done: 1'b1};
        vecs[5] = '{mode: MODE_RAMP, tgt: 50,  duty: 50,  load: 1'b0, done: 1'b1};
        vecs[6] = '{mode: MODE_SET,  tgt: 0,   duty: 0,   load: 1'b1, done: 1'b1};

        repeat (3) step();
        chk("rst_duty", int'(duty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_load", int'(duty_load), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", int'(cmd_ready), 1);

        foreach (vecs[i]) begin
            q.push_back('{duty: vecs[i].duty, load: vecs[i].load, done: vecs[i].done, busy: 1'b0});
            cmd(vecs[i].mode, vecs[i].tgt, 1'b0);
            pop_chk($sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d_done_once", i), int'(done), 0);
            chk($sformatf("vec%0d_load_once", i), int'(duty_load), 0);
            chk($sformatf("vec%0d_busy_after", i), int'(busy), 0);
        end
        cur = 0;

        run_ramp("ramp23", MODE_RAMP, 23);
        run_ramp("ramp3", MODE_RAMP, 3);
        run_ramp("ramp200", MODE_RAMP, 200);
        cmd(MODE_SET, 0, 1'b0);
        chk("set0_duty", int'(duty), 0);
        cur = 0;

`ifdef PWM_RAMP_BREATHE_EN
        cmd(MODE_BRTH, 10, 1'b1);
        chk("brth_start_duty", int'(duty), 0);
        chk("brth_start_busy", int'(busy), 1);
        chk("brth_start_ready", int'(cmd_ready), 1);
        chk("brth_start_done", int'(done), 0);
        foreach (vecs[i]) if (i < 5) q.push_back('{duty: (i == 1) ? 10 : (i == 3) ? 0 : 5, load: 1'b1, done: 1'b0, busy: 1'b1});
        repeat (5) begin
            tick();
            pop_chk("brth");
        end
        cmd(MODE_STOP, 0, 1'b1);
        chk("brth_stop_duty", int'(duty), 5);
        chk("brth_stop_done", int'(done), 1);
        chk("brth_stop_busy", int'(busy), 0);
        chk("brth_stop_load", int'(duty_load), 0);
        cmd(MODE_BRTH, 0, 1'b0);
        chk("brth0_duty", int'(duty), 0);
        chk("brth0_done", int'(done), 1);
        chk("brth0_busy", int'(busy), 0);
        cmd(MODE_BRTH, 20, 1'b0);
        tick();
        chk("abort_pre_duty", int'(duty), 5);
        cmd(MODE_SET, 30, 1'b1);
        chk("abort_duty", int'(duty), 30);
        chk("abort_done", int'(done), 1);
        chk("abort_busy", int'(busy), 0);
        cmd(MODE_SET, 0, 1'b0);
        cur = 0;
`else
        run_ramp("brth_as_ramp", MODE_BRTH, 10);
        cmd(MODE_SET, 0, 1'b0);
        cur = 0;
`endif

        cmd(MODE_RAMP, 40, 1'b0);
        repeat (3) tick();
        chk("mid_ramp_duty", int'(duty), 15);
        chk("mid_ramp_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("rst_mid_duty", int'(duty), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        chk("rel_ready_low", int'(cmd_ready), 0);
        step();
        chk("rel_ready_high", int'(cmd_ready), 1);
        cmd(MODE_RAMP, 0, 1'b0);
        chk("post_rst_ramp0_done", int'(done), 1);
        chk("post_rst_ramp0_busy", int'(busy), 0);
        chk("post_rst_ramp0_load", int'(duty_load), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
